finv_nr_recip: RTL and testbench

//  Iterative Newton-Raphson reciprocal unit; sits directly upstream of the fdiv multiply stage.

---
 rtl/finv_pkg.sv | 43 ++++
 rtl/finv_mul.sv | 18 +
 rtl/finv_nr_recip.sv | 151 +++++++++++++++
 tb/tb_finv_nr_recip.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/finv_pkg.sv
// finv_pkg: shared types and constants for the Newton-Raphson reciprocal unit.
// Fixed-point values are Q2.W unsigned: two integer bits above W fraction bits.
package finv_pkg;

  localparam int FW = 28;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SEED, ST_MUL_A, ST_MUL_B, ST_ROUND, ST_DONE
  } state_t;

  // Divisor classes that bypass the iteration result
  typedef enum logic [1:0] {
    SP_NONE, SP_DBZ, SP_NANINF, SP_POW2
  } spec_t;

  // num/17 in Q2.w, truncated
  function automatic logic [63:0] q_div17(input int unsigned num, input int unsigned w);
    return (64'(num) << w) / 64'd17;
  endfunction

  localparam logic [FW+1:0] C48_17    = (FW+2)'(q_div17(48, FW));
  localparam logic [FW+1:0] C32_17    = (FW+2)'(q_div17(32, FW));
  localparam logic [22:0]   ROUND_SAT = 23'h7FFFFF;

  // Zero/denormal wins over inf/nan, which wins over an exact power of two
  function automatic spec_t classify(input logic [31:0] x);
    if (x[30:23] == 8'h00)      return SP_DBZ;
    else if (x[30:23] == 8'hFF) return SP_NANINF;
    else if (x[22:0] == 23'd0)  return SP_POW2;
    else                        return SP_NONE;
  endfunction

  // Result word for the bypass classes
  function automatic logic [31:0] spec_word(input spec_t k, input logic [31:0] x);
    case (k)
      SP_DBZ:    return {x[31], 31'd0};
      SP_NANINF: return x;
      SP_POW2:   return {x[31], x[30:23] - 8'd1, 23'd0};
      default:   return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/finv_mul.sv
// finv_mul: combinational unsigned Q2.W x Q2.W multiply, truncated back to Q2.W.
// Callers guarantee the true product is below 4.0, so dropping the top bits is safe.
module finv_mul #(
  parameter int W = 28
) (
  input  logic [W+1:0] i_a,
  input  logic [W+1:0] i_b,
  output logic [W+1:0] o_p
);

  logic [2*W+3:0] w_full;
  logic           w_unused;

  assign w_full   = {{(W+2){1'b0}}, i_a} * {{(W+2){1'b0}}, i_b};
  assign o_p      = w_full[2*W+1:W];
  assign w_unused = ^{w_full[2*W+3:2*W+2], w_full[W-1:0]};

endmodule

// File: rtl/finv_nr_recip.sv
// finv_nr_recip: iterative Newton-Raphson reciprocal producing {s2, e2, frac(2/1.m2)}
// for the fdiv multiply stage; x1 rides along as sideband.
// Optional feature macro FINV_EARLY_EXIT_EN: special divisors skip straight to DONE.
module finv_nr_recip
  import finv_pkg::*;
#(
  parameter int ITERS = 3,
  parameter int W     = FW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1_in,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] x1_out,
  output logic [31:0] y,
  output logic        dbz,
  output logic        nan_inf
);

  localparam int IW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [W+1:0] K48 = (W+2)'(q_div17(48, W));
  localparam logic [W+1:0] K32 = (W+2)'(q_div17(32, W));
  localparam logic [W+1:0] TWO = {2'b10, {W{1'b0}}};

  state_t        r_state, w_next;
  spec_t         r_spec, w_spec;
  logic [W+1:0]  r_d, r_y, r_t;
  logic [W+1:0]  w_a, w_b, w_p;
  logic [IW-1:0] r_iter;
  logic [31:0]   r_x2, r_x1_out, r_y_out;
  logic          r_dbz, r_ni;
  logic          w_acc, w_last;
  logic [23:0]   w_rnd;
  logic [22:0]   w_mr;
  logic [31:0]   w_res;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign x1_out    = r_x1_out;
  assign y         = r_y_out;
  assign dbz       = r_dbz;
  assign nan_inf   = r_ni;

  assign w_acc  = in_valid && (r_state == ST_IDLE);
  assign w_spec = classify(x2);
  assign w_last = (r_iter == IW'(ITERS - 1));

  // Single multiplier shared by seed, d*y and y*(2-t) steps
  finv_mul #(.W(W)) u_mul (.i_a(w_a), .i_b(w_b), .o_p(w_p));

  // Operand select for the shared multiplier
  always_comb begin
    w_a = '0;
    w_b = '0;
    case (r_state)
      ST_SEED:  begin w_a = K32; w_b = r_d; end
      ST_MUL_A: begin w_a = r_d; w_b = r_y; end
      ST_MUL_B: begin w_a = r_y; w_b = TWO - r_t; end
      default:  ;
    endcase
  end

  // Round 23 fraction bits to nearest; y >= 2.0 or a carry out saturates
  always_comb begin
    w_rnd = {1'b0, r_y[W-1:W-23]} + 24'(r_y[W-24]);
    w_mr  = (r_y[W+1] || w_rnd[23]) ? ROUND_SAT : w_rnd[22:0];
    w_res = (r_spec != SP_NONE) ? spec_word(r_spec, r_x2) : {r_x2[31:23], w_mr};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: seed, ITERS multiply pairs, round, hold until taken
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
`ifdef FINV_EARLY_EXIT_EN
          w_next = (w_spec != SP_NONE) ? ST_DONE : ST_SEED;
`else
          w_next = ST_SEED;
`endif
        end
      end
      ST_SEED:  w_next = ST_MUL_A;
      ST_MUL_A: w_next = ST_MUL_B;
      ST_MUL_B: w_next = w_last ? ST_ROUND : ST_MUL_A;
      ST_ROUND: w_next = ST_DONE;
      ST_DONE:  if (out_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Datapath: capture at accept, iterate, then publish the result word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d      <= '0;
      r_y      <= '0;
      r_t      <= '0;
      r_iter   <= '0;
      r_x2     <= '0;
      r_x1_out <= '0;
      r_y_out  <= '0;
      r_spec   <= SP_NONE;
      r_dbz    <= 1'b0;
      r_ni     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_d      <= {2'b00, 1'b1, x2[22:0], {(W-24){1'b0}}};
            r_x2     <= x2;
            r_x1_out <= x1_in;
            r_spec   <= w_spec;
            r_iter   <= '0;
            r_dbz    <= 1'b0;
            r_ni     <= 1'b0;
`ifdef FINV_EARLY_EXIT_EN
            if (w_spec != SP_NONE) begin
              r_y_out <= spec_word(w_spec, x2);
              r_dbz   <= (w_spec == SP_DBZ);
              r_ni    <= (w_spec == SP_NANINF);
            end
`endif
          end
        end
        ST_SEED:  r_y <= K48 - w_p;
        ST_MUL_A: r_t <= w_p;
        ST_MUL_B: begin
          r_y    <= w_p;
          r_iter <= w_last ? '0 : r_iter + IW'(1);
        end
        ST_ROUND: begin
          r_y_out <= w_res;
          r_dbz   <= (r_spec == SP_DBZ);
          r_ni    <= (r_spec == SP_NANINF);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_finv_nr_recip.sv
// tb_finv_nr_recip: directed corner cases plus random divisors checked against a
// real-number model of 2/1.m2 (mantissa within 1 ulp of the correctly rounded value).
module tb_finv_nr_recip;

  localparam int LAT_N = 8;
`ifdef FINV_EARLY_EXIT_EN
  localparam int LAT_S = 0;   // out_valid visible in the cycle right after accept
`else
  localparam int LAT_S = 8;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [31:0] x1_in, x2;
  logic        in_ready, out_valid, dbz, nan_inf;
  logic [31:0] x1_out, y;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  finv_nr_recip dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x1_in(x1_in), .x2(x2), .out_valid(out_valid), .out_ready(out_ready),
    .x1_out(x1_out), .y(y), .dbz(dbz), .nan_inf(nan_inf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Correctly rounded 23-bit fraction of 2/1.m
  function automatic int ref_mant(input logic [22:0] m);
    real r;
    r = 2.0 / (1.0 + real'(m) / 8388608.0);
    r = (r - 1.0) * 8388608.0;
    return $rtoi(r + 0.5);
  endfunction

  // Issue one operation; returns outputs at the first out_valid cycle.
  // Called #1 after a rising edge; consumes the result only if out_ready is high.
  task automatic do_op(input logic [31:0] a1, input logic [31:0] b2,
                       output logic [31:0] ry, output logic [31:0] rx1,
                       output logic rdbz, output logic rni, output int lat);
    int g = 0;
    while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1; x1_in = a1; x2 = b2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("out_valid_wait", 32'(out_valid), 32'd1);
    ry = y; rx1 = x1_out; rdbz = dbz; rni = nan_inf;
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  task automatic chk_normal(input logic [31:0] b2, input logic [31:0] ry);
    int d;
    d = int'(ry[22:0]) - ref_mant(b2[22:0]);
    if (d < 0) d = -d;
    chk("norm_se", 32'(ry[31:23]), 32'(b2[31:23]));
    chk("norm_ulp_ok", 32'(d <= 1), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ry, rx1, y0, a1, b2, ey;
    logic        rd, rn, s;
    logic [7:0]  e;
    logic [22:0] m;
    int          lat, k;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x1_in = '0; x2 = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_x1_out", x1_out, 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);
    chk("rst_nan_inf", 32'(nan_inf), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 3.0 -> 2/1.5 = 1.333..
    do_op(32'h3F800000, 32'h40400000, ry, rx1, rd, rn, lat);
    chk("three_y", 32'(ry == 32'h402AAAAA || ry == 32'h402AAAAB), 32'd1);
    chk("three_x1", rx1, 32'h3F800000);
    chk("three_lat", 32'(lat), 32'(LAT_N));
    chk("three_dbz", 32'(rd), 32'd0);

    // 2.0 -> exact power of two
    do_op(32'h12345678, 32'h40000000, ry, rx1, rd, rn, lat);
    chk("two_y", ry, 32'h3F800000);
    chk("two_dbz", 32'(rd), 32'd0);
    chk("two_ni", 32'(rn), 32'd0);
    chk("two_lat", 32'(lat), 32'(LAT_S));

    // -0 -> divide by zero
    do_op(32'h0, 32'h80000000, ry, rx1, rd, rn, lat);
    chk("nz_dbz", 32'(rd), 32'd1);
    chk("nz_y", ry, 32'h80000000);
    chk("nz_ni", 32'(rn), 32'd0);

    // inf -> pass-through; dbz from previous op must be cleared
    do_op(32'h0, 32'h7F800000, ry, rx1, rd, rn, lat);
    chk("inf_ni", 32'(rn), 32'd1);
    chk("inf_y", ry, 32'h7F800000);
    chk("inf_dbz", 32'(rd), 32'd0);

    // mantissa all ones: result just above 1.0, must not saturate
    do_op(32'h0, 32'h3FFFFFFF, ry, rx1, rd, rn, lat);
    chk_normal(32'h3FFFFFFF, ry);

    // downstream stall for 5 cycles
    out_ready = 1'b0;
    do_op(32'hCAFEF00D, 32'h40A00000, y0, rx1, rd, rn, lat);
    chk_normal(32'h40A00000, y0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_y", y, y0);
      chk("stall_x1", x1_out, 32'hCAFEF00D);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);

    // reset while in MUL_B discards the operation
    x2 = 32'h40400000; x1_in = 32'h1; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;   // SEED
    @(posedge clk); #1;                    // MUL_A
    @(posedge clk); #1;                    // MUL_B
    rst = 1'b1; #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    do_op(32'h2, 32'h40A00000, ry, rx1, rd, rn, lat);
    chk_normal(32'h40A00000, ry);
    chk("postrst_x1", rx1, 32'h2);

    // random divisors, with a share of special classes
    for (int i = 0; i < 2000; i++) begin
      s  = 1'($urandom_range(0, 1));
      e  = 8'($urandom_range(1, 254));
      m  = 23'($urandom);
      k  = $urandom_range(0, 9);
      if (k == 0) e = 8'h00;
      else if (k == 1) e = 8'hFF;
      else if (k == 2) m = 23'd0;
      else if (m == 23'd0) m = 23'd1;
      b2 = {s, e, m};
      a1 = $urandom;
      do_op(a1, b2, ry, rx1, rd, rn, lat);
      chk("rnd_x1", rx1, a1);
      chk("rnd_dbz", 32'(rd), 32'(e == 8'h00));
      chk("rnd_ni", 32'(rn), 32'(e == 8'hFF));
      if (e == 8'h00) begin
        ey = {s, 31'd0};
        chk("rnd_dbz_y", ry, ey);
        chk("rnd_lat", 32'(lat), 32'(LAT_S));
      end else if (e == 8'hFF) begin
        chk("rnd_ni_y", ry, b2);
        chk("rnd_lat", 32'(lat), 32'(LAT_S));
      end else if (m == 23'd0) begin
        ey = {s, e - 8'd1, 23'd0};
        chk("rnd_pow2_y", ry, ey);
        chk("rnd_lat", 32'(lat), 32'(LAT_S));
      end else begin
        chk_normal(b2, ry);
        chk("rnd_lat", 32'(lat), 32'(LAT_N));
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
